// File: rtl/write_txn_arbiter_if.sv
// Signal bundle between the two write masters' request side and the write
// transaction arbiter: AW requests, granted-path handshakes, grant/route/status.
interface write_txn_arbiter_if;
   logic        AWVALID_M0;
   logic        AWVALID_M1;
   logic [31:0] AWADDR_M0;
   logic [31:0] AWADDR_M1;
   logic        aw_hs;
   logic        w_hs;
   logic        wlast;
   logic        b_hs;
   logic [1:0]  grant;
   logic [4:0]  slave_sel;
   logic        busy;
   logic        timeout;

   modport master (
      output AWVALID_M0, AWVALID_M1, AWADDR_M0, AWADDR_M1,
      output aw_hs, w_hs, wlast, b_hs,
      input  grant, slave_sel, busy, timeout
   );

   modport slave (
      input  AWVALID_M0, AWVALID_M1, AWADDR_M0, AWADDR_M1,
      input  aw_hs, w_hs, wlast, b_hs,
      output grant, slave_sel, busy, timeout
   );
endinterface

// File: rtl/write_txn_arbiter.sv
// Two-master write transaction arbiter: round-robin AW grant, address decode to
// a one-hot slave route held for the whole transaction, and a DATA/RESP watchdog.
module write_txn_arbiter #(
   parameter int unsigned TIMEOUT = 255
) (
   input logic                clk,
   input logic                rst,
   write_txn_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2,
      RESP = 2'd3
   } state_t;

   localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT);
   localparam logic [7:0] WD_MAX   = 8'hFF;

   state_t     state_q, state_d;
   logic       ptr_q, ptr_d;
   logic [1:0] grant_q, grant_d;
   logic [4:0] sel_q, sel_d;
   logic [7:0] wd_q, wd_d;
   logic       pick_m1;
   logic       wd_expired;
   logic       busy_o;
   logic       timeout_o;

   function automatic logic [4:0] decode_slave(input logic [31:0] addr);
      logic [4:0] sel;
      if (addr[31:14] == 18'd0)              sel = 5'b00001;
      else if (addr[31:16] == 16'h0001)      sel = 5'b00010;
      else if (addr[31:16] == 16'h0002)      sel = 5'b00100;
      else if (addr[31:10] == 22'h04_0000)   sel = 5'b01000;
      else                                   sel = 5'b10000;
      return sel;
   endfunction

   // The watchdog only aborts once the write burst is under way.
   assign wd_expired = ((state_q == DATA) || (state_q == RESP)) && (wd_q == WD_LIMIT);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         ptr_q   <= 1'b0;
         grant_q <= 2'b00;
         sel_q   <= 5'b00000;
         wd_q    <= 8'd0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         sel_q   <= sel_d;
         wd_q    <= wd_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      grant_d = grant_q;
      sel_d   = sel_q;
      wd_d    = wd_q;
      pick_m1 = ptr_q ? bus.AWVALID_M1 : ~bus.AWVALID_M0;

      unique case (state_q)
         IDLE: begin
            if (bus.AWVALID_M0 | bus.AWVALID_M1) begin
               state_d = ADDR;
               grant_d = pick_m1 ? 2'b10 : 2'b01;
               sel_d   = decode_slave(pick_m1 ? bus.AWADDR_M1 : bus.AWADDR_M0);
               ptr_d   = ~pick_m1;
            end
         end
         ADDR: begin
            if (bus.aw_hs) state_d = DATA;
         end
         DATA: begin
            if (wd_expired)                   state_d = IDLE;
            else if (bus.w_hs & bus.wlast)    state_d = RESP;
         end
         RESP: begin
            if (wd_expired | bus.b_hs) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if ((state_q != IDLE) && (state_d == IDLE)) begin
         grant_d = 2'b00;
         sel_d   = 5'b00000;
      end

      // Any state change or write beat restarts the idle-handshake count.
      if ((state_d != state_q) || (state_q == IDLE) || bus.w_hs) wd_d = 8'd0;
      else if (wd_q != WD_MAX)                                     wd_d = wd_q + 8'd1;
   end

   always_comb begin
      busy_o    = (state_q != IDLE);
      timeout_o = wd_expired & rst;
   end

   assign bus.grant     = grant_q;
   assign bus.slave_sel = sel_q;
   assign bus.busy      = busy_o;
   assign bus.timeout   = timeout_o;

endmodule

// File: tb/tb_write_txn_arbiter.sv
// Bench for write_txn_arbiter: vector table, directed multi-cycle sequences and
// randomized traffic against a transaction-level reference model.
module tb_write_txn_arbiter;

   localparam int TMO = 8;
   localparam int PH_IDLE = 0;
   localparam int PH_ADDR = 1;
   localparam int PH_DATA = 2;
   localparam int PH_RESP = 3;
   localparam logic [31:0] A0 = 32'h1000_0000;
   localparam logic [31:0] A1 = 32'h0002_0010;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   write_txn_arbiter_if bus();
   write_txn_arbiter #(.TIMEOUT(TMO)) dut (.clk(clk), .rst(rst), .bus(bus));

   int checks = 0;
   int errors = 0;

   // Reference model: who owns the fabric, which phase it is in, where it goes.
   int m_phase = PH_IDLE;
   int m_owner = -1;
   int m_target = 0;
   int m_pref = 0;
   int m_quiet = 0;

   typedef struct {
      logic        rst_n;
      logic        v0;
      logic        v1;
      logic [31:0] a0;
      logic [31:0] a1;
      logic        aw;
      logic        w;
      logic        wl;
      logic        b;
      logic [1:0]  g;
      logic [4:0]  s;
      logic        bz;
      logic        to;
   } vec_t;

   vec_t vecs [23];

   function automatic vec_t mk(input logic r, input logic v0, input logic v1,
                               input logic aw, input logic w, input logic wl, input logic b,
                               input logic [1:0] g, input logic [4:0] s, input logic bz);
      vec_t v;
      v.rst_n = r;  v.v0 = v0;  v.v1 = v1;  v.a0 = A0;  v.a1 = A1;
      v.aw = aw;  v.w = w;  v.wl = wl;  v.b = b;
      v.g = g;  v.s = s;  v.bz = bz;  v.to = 1'b0;
      return v;
   endfunction

   function automatic int slave_index(input logic [31:0] a);
      if (a <= 32'h0000_3FFF) return 0;
      if (a >= 32'h0001_0000 && a <= 32'h0001_FFFF) return 1;
      if (a >= 32'h0002_0000 && a <= 32'h0002_FFFF) return 2;
      if (a >= 32'h1000_0000 && a <= 32'h1000_03FF) return 3;
      return 4;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic model_step();
      int win;
      int nxt;
      if (!rst) begin
         m_phase = PH_IDLE;  m_owner = -1;  m_pref = 0;  m_quiet = 0;
         return;
      end
      nxt = (m_quiet < 255) ? m_quiet + 1 : 255;
      case (m_phase)
         PH_IDLE: begin
            if (bus.AWVALID_M0 || bus.AWVALID_M1) begin
               if (m_pref == 0) win = bus.AWVALID_M0 ? 0 : 1;
               else             win = bus.AWVALID_M1 ? 1 : 0;
               m_owner  = win;
               m_target = slave_index(win == 1 ? bus.AWADDR_M1 : bus.AWADDR_M0);
               m_pref   = 1 - win;
               m_phase  = PH_ADDR;
               m_quiet  = 0;
            end
         end
         PH_ADDR: begin
            if (bus.aw_hs) begin m_phase = PH_DATA; m_quiet = 0; end
            else m_quiet = bus.w_hs ? 0 : nxt;
         end
         PH_DATA: begin
            if (m_quiet == TMO) begin m_phase = PH_IDLE; m_owner = -1; m_quiet = 0; end
            else if (bus.w_hs && bus.wlast) begin m_phase = PH_RESP; m_quiet = 0; end
            else m_quiet = bus.w_hs ? 0 : nxt;
         end
         default: begin
            if (m_quiet == TMO || bus.b_hs) begin m_phase = PH_IDLE; m_owner = -1; m_quiet = 0; end
            else m_quiet = bus.w_hs ? 0 : nxt;
         end
      endcase
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic drive(input logic v0, input logic v1, input logic [31:0] a0, input logic [31:0] a1,
                        input logic aw, input logic w, input logic wl, input logic b);
      bus.AWVALID_M0 = v0;  bus.AWVALID_M1 = v1;
      bus.AWADDR_M0  = a0;  bus.AWADDR_M1  = a1;
      bus.aw_hs = aw;  bus.w_hs = w;  bus.wlast = wl;  bus.b_hs = b;
   endtask

   task automatic finish_txn(input string tag);
      bus.aw_hs = 1'b1;                    tick();
      bus.aw_hs = 1'b0; bus.w_hs = 1'b1; bus.wlast = 1'b1; tick();
      bus.w_hs = 1'b0;  bus.wlast = 1'b0; bus.b_hs = 1'b1; tick();
      bus.b_hs = 1'b0;
      chk({tag, " busy after b_hs"}, 32'(bus.busy), 32'd0);
      chk({tag, " grant after b_hs"}, 32'(bus.grant), 32'd0);
   endtask

   logic [31:0] sweep_addr [8];
   logic [4:0]  sweep_sel  [8];
   logic [31:0] addr_pool  [8];

   initial begin
      rst = 1'b0;
      drive(0, 0, 32'd0, 32'd0, 0, 0, 0, 0);

      //        rst v0 v1 aw w wl b   grant  sel        busy
      vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 5'b00000, 0);
      vecs[1]  = mk(1, 0, 1, 0, 0, 0, 0, 2'b10, 5'b00100, 1);
      vecs[2]  = mk(1, 0, 0, 1, 0, 0, 0, 2'b10, 5'b00100, 1);
      vecs[3]  = mk(1, 0, 0, 0, 1, 0, 0, 2'b10, 5'b00100, 1);
      vecs[4]  = mk(1, 0, 0, 0, 1, 0, 0, 2'b10, 5'b00100, 1);
      vecs[5]  = mk(1, 0, 0, 0, 1, 0, 0, 2'b10, 5'b00100, 1);
      vecs[6]  = mk(1, 0, 0, 0, 1, 1, 0, 2'b10, 5'b00100, 1);
      vecs[7]  = mk(1, 0, 0, 0, 0, 0, 1, 2'b00, 5'b00000, 0);
      vecs[8]  = mk(1, 0, 0, 1, 1, 1, 1, 2'b00, 5'b00000, 0);
      vecs[9]  = mk(1, 1, 1, 0, 0, 0, 0, 2'b01, 5'b01000, 1);
      vecs[10] = mk(1, 1, 1, 1, 0, 0, 0, 2'b01, 5'b01000, 1);
      vecs[11] = mk(1, 1, 1, 0, 0, 1, 1, 2'b01, 5'b01000, 1);
      vecs[12] = mk(1, 1, 1, 0, 1, 1, 0, 2'b01, 5'b01000, 1);
      vecs[13] = mk(1, 1, 1, 0, 0, 0, 1, 2'b00, 5'b00000, 0);
      vecs[14] = mk(1, 1, 1, 0, 0, 0, 0, 2'b10, 5'b00100, 1);
      vecs[15] = mk(1, 1, 1, 1, 1, 1, 1, 2'b10, 5'b00100, 1);
      vecs[16] = mk(1, 1, 1, 0, 0, 0, 1, 2'b10, 5'b00100, 1);
      vecs[17] = mk(1, 1, 1, 0, 1, 1, 0, 2'b10, 5'b00100, 1);
      vecs[18] = mk(1, 1, 1, 0, 0, 0, 1, 2'b00, 5'b00000, 0);
      vecs[19] = mk(1, 1, 1, 0, 0, 0, 0, 2'b01, 5'b01000, 1);
      vecs[20] = mk(0, 1, 1, 0, 0, 0, 0, 2'b00, 5'b00000, 0);
      vecs[21] = mk(1, 1, 1, 0, 0, 0, 0, 2'b01, 5'b01000, 1);
      vecs[22] = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 5'b00000, 0);

      foreach (vecs[i]) begin
         rst = vecs[i].rst_n;
         drive(vecs[i].v0, vecs[i].v1, vecs[i].a0, vecs[i].a1,
               vecs[i].aw, vecs[i].w, vecs[i].wl, vecs[i].b);
         tick();
         chk($sformatf("vec%0d grant", i),   32'(bus.grant),     32'(vecs[i].g));
         chk($sformatf("vec%0d sel", i),     32'(bus.slave_sel), 32'(vecs[i].s));
         chk($sformatf("vec%0d busy", i),    32'(bus.busy),      32'(vecs[i].bz));
         chk($sformatf("vec%0d timeout", i), 32'(bus.timeout),   32'(vecs[i].to));
      end

      rst = 1'b1;
      drive(0, 0, 32'd0, 32'd0, 0, 0, 0, 0);
      tick();

      // Decode sweep through M0 alone.
      sweep_addr = '{32'h0000_3FFF, 32'h0000_4000, 32'h0001_0000, 32'h1000_03FF,
                     32'h1000_0400, 32'h0001_FFFF, 32'h0002_0000, 32'h0000_0000};
      sweep_sel  = '{5'b00001, 5'b10000, 5'b00010, 5'b01000,
                     5'b10000, 5'b00010, 5'b00100, 5'b00001};
      for (int i = 0; i < 8; i++) begin
         bus.AWVALID_M0 = 1'b1;  bus.AWADDR_M0 = sweep_addr[i];
         tick();
         chk($sformatf("decode 0x%08h", sweep_addr[i]), 32'(bus.slave_sel), 32'(sweep_sel[i]));
         bus.AWVALID_M0 = 1'b0;
         finish_txn("decode");
      end

      // Watchdog abort in RESP, then a late b_hs.
      bus.AWVALID_M0 = 1'b1;  bus.AWADDR_M0 = 32'h0001_0040;
      tick();
      bus.AWVALID_M0 = 1'b0;  bus.aw_hs = 1'b1;
      tick();
      bus.aw_hs = 1'b0;  bus.w_hs = 1'b1;  bus.wlast = 1'b1;
      tick();
      bus.w_hs = 1'b0;  bus.wlast = 1'b0;
      for (int k = 1; k < TMO; k++) begin
         tick();
         chk($sformatf("wd resp cycle %0d timeout", k), 32'(bus.timeout), 32'd0);
         chk($sformatf("wd resp cycle %0d busy", k),    32'(bus.busy),    32'd1);
      end
      tick();
      chk("wd pulse", 32'(bus.timeout), 32'd1);
      tick();
      chk("wd after pulse timeout", 32'(bus.timeout),   32'd0);
      chk("wd after pulse busy",    32'(bus.busy),      32'd0);
      chk("wd after pulse grant",   32'(bus.grant),     32'd0);
      chk("wd after pulse sel",     32'(bus.slave_sel), 32'd0);
      bus.b_hs = 1'b1;
      tick();
      bus.b_hs = 1'b0;
      chk("late b_hs busy",    32'(bus.busy),    32'd0);
      chk("late b_hs timeout", 32'(bus.timeout), 32'd0);

      // Long ADDR wait, stray handshakes in DATA, sparse beats.
      bus.AWVALID_M0 = 1'b1;  bus.AWADDR_M0 = 32'h0002_0000;
      tick();
      bus.AWVALID_M0 = 1'b0;
      for (int k = 0; k < 20; k++) begin
         tick();
         chk($sformatf("addr wait %0d timeout", k), 32'(bus.timeout), 32'd0);
         chk($sformatf("addr wait %0d grant", k),   32'(bus.grant),   32'd1);
      end
      bus.aw_hs = 1'b1;
      tick();
      bus.aw_hs = 1'b0;  bus.wlast = 1'b1;  bus.b_hs = 1'b1;
      tick();
      bus.wlast = 1'b0;  bus.b_hs = 1'b0;
      chk("stray hs busy", 32'(bus.busy), 32'd1);
      for (int c = 1; c <= 30; c++) begin
         bus.w_hs = (c % 5 == 0);
         tick();
         chk($sformatf("sparse beat %0d timeout", c), 32'(bus.timeout), 32'd0);
         chk($sformatf("sparse beat %0d busy", c),    32'(bus.busy),    32'd1);
      end
      bus.w_hs = 1'b1;  bus.wlast = 1'b1;
      tick();
      bus.w_hs = 1'b0;  bus.wlast = 1'b0;  bus.b_hs = 1'b1;
      tick();
      bus.b_hs = 1'b0;
      chk("sparse done busy", 32'(bus.busy), 32'd0);

      // Contention from reset: M0, M1, M0.
      rst = 1'b0;
      tick();
      rst = 1'b1;
      drive(1, 1, 32'h0000_0000, 32'h1000_0000, 0, 0, 0, 0);
      tick();
      chk("rr first grant", 32'(bus.grant),     32'd1);
      chk("rr first sel",   32'(bus.slave_sel), 32'b00001);
      finish_txn("rr1");
      tick();
      chk("rr second grant", 32'(bus.grant),     32'd2);
      chk("rr second sel",   32'(bus.slave_sel), 32'b01000);
      finish_txn("rr2");
      tick();
      chk("rr third grant", 32'(bus.grant), 32'd1);
      finish_txn("rr3");
      drive(0, 0, 32'd0, 32'd0, 0, 0, 0, 0);
      tick();

      // Reset in the middle of DATA.
      bus.AWVALID_M0 = 1'b1;  bus.AWADDR_M0 = 32'h0000_4000;
      tick();
      chk("midrst pre grant", 32'(bus.grant),     32'd1);
      chk("midrst pre sel",   32'(bus.slave_sel), 32'b10000);
      bus.AWVALID_M0 = 1'b0;  bus.aw_hs = 1'b1;
      tick();
      bus.aw_hs = 1'b0;  rst = 1'b0;
      tick();
      chk("midrst grant",   32'(bus.grant),     32'd0);
      chk("midrst sel",     32'(bus.slave_sel), 32'd0);
      chk("midrst busy",    32'(bus.busy),      32'd0);
      chk("midrst timeout", 32'(bus.timeout),   32'd0);
      rst = 1'b1;  bus.AWVALID_M0 = 1'b1;  bus.AWVALID_M1 = 1'b1;
      tick();
      chk("midrst regrant", 32'(bus.grant), 32'd1);
      bus.AWVALID_M0 = 1'b0;  bus.AWVALID_M1 = 1'b0;
      finish_txn("midrst");

      // Randomized traffic against the model.
      addr_pool = '{32'h0000_3FFF, 32'h0000_4000, 32'h0001_0000, 32'h0001_FFFF,
                    32'h0002_0010, 32'h1000_0000, 32'h1000_03FF, 32'h1000_0400};
      rst = 1'b0;
      tick();
      rst = 1'b1;
      for (int n = 0; n < 3000; n++) begin
         rst            = ($urandom_range(0, 99) != 0);
         bus.AWVALID_M0 = ($urandom_range(0, 2) == 0);
         bus.AWVALID_M1 = ($urandom_range(0, 2) == 0);
         bus.AWADDR_M0  = ($urandom_range(0, 9) < 8) ? addr_pool[$urandom_range(0, 7)] : $urandom;
         bus.AWADDR_M1  = ($urandom_range(0, 9) < 8) ? addr_pool[$urandom_range(0, 7)] : $urandom;
         bus.aw_hs      = ($urandom_range(0, 2) == 0);
         bus.w_hs       = ($urandom_range(0, 2) == 0);
         bus.wlast      = ($urandom_range(0, 1) == 0);
         bus.b_hs       = ($urandom_range(0, 9) == 0);
         tick();
         chk($sformatf("rand%0d grant", n),
             32'(bus.grant), (m_owner < 0) ? 32'd0 : 32'(1 << m_owner));
         chk($sformatf("rand%0d sel", n),
             32'(bus.slave_sel), (m_owner < 0) ? 32'd0 : 32'(1 << m_target));
         chk($sformatf("rand%0d busy", n),
             32'(bus.busy), 32'(m_phase != PH_IDLE));
         chk($sformatf("rand%0d timeout", n), 32'(bus.timeout),
             32'((m_phase == PH_DATA || m_phase == PH_RESP) && m_quiet == TMO && rst));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/write_txn_arbiter.md
WRITE_TXN_ARBITER -- requirements
Module: write_txn_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: idle-handshake cycles in DATA/RESP before forced abort (range 1..255).
REQ-002 SHALL have ports: clk  in  1  clock; rising edge only.
REQ-003 SHALL have ports: rst  in  1  reset; synchronous, active-low.
REQ-004 SHALL have ports: AWVALID_M0, AWVALID_M1  in  1 each  write-address request per master.
REQ-005 SHALL have ports: AWADDR_M0, AWADDR_M1  in  32 each  request address.
REQ-006 SHALL have ports: aw_hs  in  1  AW handshake completed on granted path.
REQ-007 SHALL have ports: w_hs  in  1  W beat handshake on granted path.
REQ-008 SHALL have ports: wlast  in  1  WLAST of the current granted beat.
REQ-009 SHALL have ports: b_hs  in  1  B handshake on granted path.
REQ-010 SHALL have ports: grant  out  2  one-hot master grant; bit0=M0, bit1=M1.
REQ-011 SHALL have ports: slave_sel  out  5  one-hot {SDEFAULT,S3,S2,S1,S0} route for AW/W/B muxes.
REQ-012 SHALL have ports: busy  out  1  high in every state except IDLE.
REQ-013 SHALL have ports: timeout  out  1  one-cycle pulse on watchdog abort.

Function
REQ-014 SHALL implement states IDLE, ADDR, DATA, RESP; one write transaction owns the fabric from grant to b_hs.
REQ-015 SHALL in IDLE, with any AWVALID high, grant one master and go to ADDR next cycle; grant/slave_sel registered, valid from ADDR entry.
REQ-016 SHALL arbitrate round-robin: 1-bit pointer names preferred master; the other master wins only if the preferred one is not requesting.
REQ-017 SHALL update pointer to the non-granted master on entry to ADDR.
REQ-018 SHALL latch slave_sel from the winning AWADDR at grant and hold it, with grant, stable until return to IDLE.
REQ-019 SHALL decode: 0x0000_0000-0x0000_3FFF S0; 0x0001_0000-0x0001_FFFF S1; 0x0002_0000-0x0002_FFFF S2; 0x1000_0000-0x1000_03FF S3; otherwise SDEFAULT.
REQ-020 SHALL go ADDR->DATA on aw_hs; ignore w_hs, wlast, b_hs in ADDR.
REQ-021 SHALL go DATA->RESP on w_hs & wlast; w_hs without wlast stays in DATA.
REQ-022 SHALL go RESP->IDLE on b_hs; grant and slave_sel read 0 in the IDLE cycle; re-arbitration earliest one cycle after return (min 1 idle cycle between transactions).
REQ-023 SHALL ignore aw_hs, w_hs, wlast, b_hs in IDLE.
REQ-024 SHALL keep an 8-bit watchdog counter: cleared on state change and on w_hs; increments each cycle in ADDR, DATA, RESP otherwise, saturating.
REQ-025 SHALL, when watchdog equals TIMEOUT in DATA or RESP, go to IDLE, pulse timeout for exactly that transition cycle, clear grant/slave_sel; ADDR never times out.
REQ-026 SHALL NOT change grant while busy, regardless of AWVALID of either master.
REQ-027 SHALL treat simultaneous AWVALID_M0 & AWVALID_M1 in IDLE per pointer only.

Reset
REQ-028 SHALL, on clk rising edge with rst=0, force state IDLE, grant=2'b00, slave_sel=5'b00000, busy=0, timeout=0, watchdog=0, pointer=M0.
REQ-029 SHALL abandon any in-progress transaction on reset with no timeout pulse; reset dominates all other inputs.

Verification
REQ-030 Single write: AWVALID_M1, AWADDR_M1=0x0002_0010, aw_hs, 4 w_hs with wlast on 4th, b_hs -> grant=2'b10, slave_sel=5'b00100 from ADDR to RESP, busy low the cycle after b_hs.
REQ-031 Contention: both AWVALID high from reset -> M0 granted first; after its b_hs both still requesting -> M1 granted next; then M0 again.
REQ-032 Decode sweep: addresses 0x0000_3FFF, 0x0000_4000, 0x0001_0000, 0x1000_03FF, 0x1000_0400 -> slave_sel 00001, 10000, 00010, 01000, 10000.
REQ-033 Watchdog: TIMEOUT=8, enter RESP, withhold b_hs -> timeout pulses one cycle 8 cycles after RESP entry, state IDLE, grant=0; late b_hs afterward ignored.
REQ-034 Stray/early handshakes: b_hs in DATA and wlast without w_hs -> no state change; w_hs each 5 cycles with TIMEOUT=8 -> no timeout.
REQ-035 Mid-transaction reset: rst=0 for one cycle during DATA -> next cycle all outputs 0, timeout stays 0, next request granted to M0.
